axi_slave_mem: RTL and testbench

Parametrised AXI4 slave memory responder for the packet-processing formal and simulation environment. It is the next generation of the fixed-response slave model: configurable data width, memory depth, base address and read latency. It adds real storage with byte strobes, FIXED/INCR/WRAP burst addressing and SLVERR reporting. It sits on the packet processor's master port, so header reads and payload writes are backed by real memory.

---
 rtl/axi_slave_mem_pkg.sv | 36 +++
 rtl/axi_burst_addr_gen.sv | 43 ++++
 rtl/axi_slave_mem.sv | 147 ++++++++++++++
 tb/tb_axi_slave_mem.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_mem_pkg.sv
// Shared types and constants for the AXI4 slave memory responder.
package axi_slave_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_DATA = 3'd1;
  localparam state_t ST_WR_RESP = 3'd2;
  localparam state_t ST_RD_WAIT = 3'd3;
  localparam state_t ST_RD_DATA = 3'd4;

  // Burst control latched at address acceptance; the address lives separately
  // because its width is a module parameter.
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic [1:0] burst;
  } ax_ctl_t;

  function automatic int unsigned log2_bytes(input int unsigned nbytes);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 8; i++)
      if ((32'd1 << i) < nbytes) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational AXI burst next-address, word index and legality check.
module axi_burst_addr_gen
  import axi_slave_mem_pkg::*;
#(
  parameter int                ADDR_W    = 32,
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_W-1:0]        addr,
  input  logic [7:0]               len,
  input  logic [2:0]               size,
  input  logic [1:0]               burst,
  output logic [ADDR_W-1:0]        next_addr,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     err
);
  localparam int          NB    = DATA_W / 8;
  localparam int unsigned LG    = log2_bytes(NB);
  localparam int          IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * NB);

  logic [ADDR_W-1:0] incr, wmask;
  logic [ADDR_W:0]   off;
  logic              wrap_len_ok;

  always_comb begin
    incr  = addr + ADDR_W'(NB);
    wmask = ((ADDR_W'(len) + ADDR_W'(1)) << LG) - ADDR_W'(1);
    // Extra MSB catches addresses below the base as a borrow.
    off   = {1'b0, addr} - {1'b0, BASE_ADDR};
    idx   = off[LG +: IDX_W];
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    case (burst)
      BURST_INCR: next_addr = incr;
      BURST_WRAP: next_addr = (addr & ~wmask) | (incr & wmask);
      default:    next_addr = addr;
    endcase
    err = off[ADDR_W] || (off >= SPAN) || (size != 3'(LG)) || (burst == 2'b11) ||
          ((burst == BURST_WRAP) && !wrap_len_ok);
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: one transaction at a time, byte strobes, FIXED/INCR/WRAP, SLVERR.
module axi_slave_mem
  import axi_slave_mem_pkg::*;
#(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 32,
  parameter int                DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                RD_WAIT   = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready
);
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(DEPTH);

  state_t            state;
  ax_ctl_t           wctl, rctl;
  logic [ADDR_W-1:0] waddr, raddr, wnext, rnext;
  logic [IDX_W-1:0]  widx, ridx;
  logic [7:0]        cnt;
  logic [3:0]        wait_cnt;
  logic              werr, w_agerr, r_agerr;
  logic              w_beat, w_last_cnt, w_beat_err, r_beat;
  logic [DATA_W-1:0] mem [DEPTH];

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_wgen (
    .addr(waddr), .len(wctl.len), .size(wctl.size), .burst(wctl.burst),
    .next_addr(wnext), .idx(widx), .err(w_agerr)
  );

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR)) u_rgen (
    .addr(raddr), .len(rctl.len), .size(rctl.size), .burst(rctl.burst),
    .next_addr(rnext), .idx(ridx), .err(r_agerr)
  );

  assign s_axi_wready = (state == ST_WR_DATA);
  assign s_axi_bvalid = (state == ST_WR_RESP);
  assign s_axi_rvalid = (state == ST_RD_DATA);
  assign w_beat       = s_axi_wvalid && s_axi_wready;
  assign w_last_cnt   = (cnt == wctl.len);
  assign w_beat_err   = w_agerr || (s_axi_wlast != w_last_cnt);
  assign r_beat       = s_axi_rvalid && s_axi_rready;
  // Read outputs derive from the held address, so they stay stable across stalls.
  assign s_axi_rlast  = s_axi_rvalid && (cnt == rctl.len);
  assign s_axi_rresp  = (s_axi_rvalid && r_agerr) ? RESP_SLVERR : RESP_OKAY;
  assign s_axi_rdata  = (s_axi_rvalid && !r_agerr) ? mem[ridx] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      s_axi_awready <= 1'b0;
      s_axi_arready <= 1'b0;
      s_axi_bresp   <= RESP_OKAY;
      waddr         <= '0;
      raddr         <= '0;
      wctl          <= '0;
      rctl          <= '0;
      cnt           <= '0;
      wait_cnt      <= '0;
      werr          <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (s_axi_awready) begin
            s_axi_awready <= 1'b0;
            waddr <= s_axi_awaddr;
            wctl  <= '{len: s_axi_awlen, size: s_axi_awsize, burst: s_axi_awburst};
            cnt   <= '0;
            werr  <= 1'b0;
            state <= ST_WR_DATA;
          end else if (s_axi_arready) begin
            s_axi_arready <= 1'b0;
            raddr    <= s_axi_araddr;
            rctl     <= '{len: s_axi_arlen, size: s_axi_arsize, burst: s_axi_arburst};
            cnt      <= '0;
            wait_cnt <= '0;
            state    <= (RD_WAIT == 0) ? ST_RD_DATA : ST_RD_WAIT;
          end else if (s_axi_awvalid) begin
            s_axi_awready <= 1'b1;
          end else if (s_axi_arvalid) begin
            s_axi_arready <= 1'b1;
          end
        end
        ST_WR_DATA: begin
          if (w_beat) begin
            werr  <= werr | w_beat_err;
            waddr <= wnext;
            cnt   <= cnt + 8'd1;
            if (w_last_cnt) begin
              s_axi_bresp <= (werr || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              state       <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: if (s_axi_bready) state <= ST_IDLE;
        ST_RD_WAIT: begin
          if (wait_cnt == 4'(RD_WAIT - 1)) state <= ST_RD_DATA;
          else wait_cnt <= wait_cnt + 4'd1;
        end
        ST_RD_DATA: begin
          if (r_beat) begin
            if (s_axi_rlast) state <= ST_IDLE;
            else begin
              raddr <= rnext;
              cnt   <= cnt + 8'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside reset; an error anywhere in the burst freezes it.
  always_ff @(posedge clk) begin
    if (w_beat && !werr && !w_beat_err)
      for (int b = 0; b < NB; b++)
        if (s_axi_wstrb[b]) mem[widx][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Scoreboard bench for axi_slave_mem: a byte-level memory model predicts B and R beats.
module tb_axi_slave_mem;
  localparam int RDW = 3;

  logic        clk = 1'b0, reset = 1'b0;
  logic [31:0] s_axi_awaddr = '0, s_axi_araddr = '0, s_axi_wdata = '0;
  logic [7:0]  s_axi_awlen = '0, s_axi_arlen = '0;
  logic [2:0]  s_axi_awsize = '0, s_axi_arsize = '0;
  logic [1:0]  s_axi_awburst = '0, s_axi_arburst = '0;
  logic [3:0]  s_axi_wstrb = '0;
  logic        s_axi_awvalid = 0, s_axi_wlast = 0, s_axi_wvalid = 0, s_axi_bready = 0;
  logic        s_axi_arvalid = 0, s_axi_rready = 0;
  logic        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic [31:0] s_axi_rdata;

  axi_slave_mem #(.DATA_W(32), .ADDR_W(32), .DEPTH(256), .BASE_ADDR(32'h0), .RD_WAIT(RDW)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen), .s_axi_awsize(s_axi_awsize),
    .s_axi_awburst(s_axi_awburst), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen), .s_axi_arsize(s_axi_arsize),
    .s_axi_arburst(s_axi_arburst), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp), .s_axi_rlast(s_axi_rlast),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct { logic [31:0] data; logic [1:0] resp; logic last; } rbeat_t;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] mdl [256];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [1:0]  exp_b [$];
  rbeat_t      exp_r [$];
  logic        mon_ar = 0, ar_early = 0;

  always @(negedge clk) if (mon_ar && s_axi_arready) ar_early = 1;

  function automatic logic [31:0] m_next(logic [31:0] a, int len, logic [1:0] burst);
    logic [31:0] win, lo;
    win = 32'((len + 1) * 4);
    if (burst == 2'b01) return a + 4;
    if (burst == 2'b10) begin
      lo = a - (a % win);
      return lo + ((a - lo + 4) % win);
    end
    return a;
  endfunction

  function automatic bit m_err(logic [31:0] a, int len, logic [1:0] burst, logic [2:0] size);
    return (a >= 32'd1024) || (size != 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  task automatic do_write(input logic [31:0] addr, input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int last_at, input int abort_after);
    logic [31:0] a;
    logic [1:0]  e;
    bit          err, be;
    int          t;
    a = addr; err = 0;
    s_axi_awaddr = addr; s_axi_awlen = 8'(len); s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1;
    t = 0;
    while (s_axi_awready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    if (s_axi_awready !== 1'b1) begin
      n_chk++; n_fail++; $display("FAIL aw_timeout awready=%b want 1", s_axi_awready);
      s_axi_awvalid = 0; return;
    end
    @(posedge clk); #1;
    s_axi_awvalid = 0;
    n_chk++;
    if (s_axi_wready !== 1'b1) begin n_fail++; $display("FAIL wready_after_aw got %b want 1", s_axi_wready); end
    for (int i = 0; i <= len; i++) begin
      if (abort_after >= 0 && i == abort_after) begin s_axi_wvalid = 0; return; end
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = (i == last_at); s_axi_wvalid = 1;
      t = 0;
      while (s_axi_wready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
      if (s_axi_wready !== 1'b1) begin
        n_chk++; n_fail++; $display("FAIL w_timeout beat %0d wready=%b want 1", i, s_axi_wready);
        s_axi_wvalid = 0; return;
      end
      be = m_err(a, len, burst, size) || ((i == last_at) != (i == len));
      err = err || be;
      if (!err)
        for (int b = 0; b < 4; b++) if (ws[i][b]) mdl[a[9:2]][b*8 +: 8] = wd[i][b*8 +: 8];
      a = m_next(a, len, burst);
      @(posedge clk); #1;
    end
    s_axi_wvalid = 0; s_axi_wlast = 0;
    exp_b.push_back(err ? 2'b10 : 2'b00);
    n_chk++;
    if (s_axi_bvalid !== 1'b1) begin n_fail++; $display("FAIL bvalid_timing got %b want 1", s_axi_bvalid); end
    s_axi_bready = 1;
    t = 0;
    while (s_axi_bvalid !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    e = exp_b.pop_front();
    n_chk++;
    if (s_axi_bvalid !== 1'b1 || s_axi_bresp !== e) begin
      n_fail++; $display("FAIL bresp addr=%h got bvalid=%b bresp=%b want bvalid=1 bresp=%b", addr, s_axi_bvalid, s_axi_bresp, e);
    end
    @(posedge clk); #1;
    s_axi_bready = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input bit toggle);
    logic [31:0] a, hold;
    rbeat_t      e;
    bit          er, stalled, rr;
    int          t, t_ar, got;
    a = addr; hold = '0; stalled = 0;
    for (int i = 0; i <= len; i++) begin
      er = m_err(a, len, burst, size);
      e.data = er ? 32'h0 : mdl[a[9:2]];
      e.resp = er ? 2'b10 : 2'b00;
      e.last = (i == len);
      exp_r.push_back(e);
      a = m_next(a, len, burst);
    end
    s_axi_araddr = addr; s_axi_arlen = 8'(len); s_axi_arsize = size; s_axi_arburst = burst;
    s_axi_arvalid = 1; s_axi_rready = 0;
    t = 0;
    while (s_axi_arready !== 1'b1 && t < 20) begin @(posedge clk); #1; t++; end
    if (s_axi_arready !== 1'b1) begin
      n_chk++; n_fail++; $display("FAIL ar_timeout arready=%b want 1", s_axi_arready);
      s_axi_arvalid = 0; exp_r.delete(); return;
    end
    t_ar = cyc;
    @(posedge clk); #1;
    s_axi_arvalid = 0;
    t = 0;
    while (s_axi_rvalid !== 1'b1 && t < 40) begin @(posedge clk); #1; t++; end
    n_chk++;
    if (cyc - t_ar != 1 + RDW) begin
      n_fail++; $display("FAIL r_latency got %0d cycles want %0d", cyc - t_ar, 1 + RDW);
    end
    rr = !toggle; got = 0; t = 0;
    while (got <= len && t < 200) begin
      s_axi_rready = rr;
      if (stalled) begin
        n_chk++;
        if (s_axi_rdata !== hold) begin n_fail++; $display("FAIL r_stable got %h want %h", s_axi_rdata, hold); end
        stalled = 0;
      end
      if (s_axi_rvalid && rr) begin
        e = exp_r.pop_front();
        n_chk++;
        if (s_axi_rdata !== e.data || s_axi_rresp !== e.resp || s_axi_rlast !== e.last) begin
          n_fail++;
          $display("FAIL r_beat addr=%h beat=%0d got data=%h resp=%b last=%b want data=%h resp=%b last=%b",
                   addr, got, s_axi_rdata, s_axi_rresp, s_axi_rlast, e.data, e.resp, e.last);
        end
        got++;
      end else if (s_axi_rvalid) begin
        hold = s_axi_rdata; stalled = 1;
      end
      @(posedge clk); #1; t++;
      if (toggle) rr = !rr;
    end
    s_axi_rready = 0;
    if (got <= len) begin
      n_chk++; n_fail++; $display("FAIL r_timeout got %0d beats want %0d", got, len + 1);
      exp_r.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp, s_axi_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_outputs got aw=%b w=%b b=%b ar=%b r=%b last=%b bresp=%b rresp=%b rdata=%h want all 0",
        s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast, s_axi_bresp, s_axi_rresp, s_axi_rdata);
    end
    reset = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(32'h10, 3, 2'b01, 3'd2, 3, -1);
    do_read(32'h10, 3, 2'b01, 3'd2, 0);
  endtask

  task automatic test_strobe();
    wd[0] = 32'h1111_1111; ws[0] = 4'hF;
    do_write(32'h40, 0, 2'b01, 3'd2, 0, -1);
    wd[0] = 32'hAABB_CCDD; ws[0] = 4'b0101;
    do_write(32'h40, 0, 2'b01, 3'd2, 0, -1);
    do_read(32'h40, 0, 2'b01, 3'd2, 0);
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hA0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h00, 3, 2'b01, 3'd2, 3, -1);
    for (int i = 0; i < 4; i++) wd[i] = 32'h10 + 32'(i);
    do_write(32'h08, 3, 2'b10, 3'd2, 3, -1);
    do_read(32'h00, 3, 2'b01, 3'd2, 0);
    do_read(32'h08, 3, 2'b10, 3'd2, 0);
    for (int i = 0; i < 3; i++) wd[i] = 32'hFF;
    do_write(32'h08, 2, 2'b10, 3'd2, 2, -1);
    do_read(32'h00, 3, 2'b01, 3'd2, 0);
  endtask

  task automatic test_slverr();
    for (int i = 0; i < 2; i++) begin wd[i] = 32'hC0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h20, 1, 2'b01, 3'd2, 1, -1);
    wd[0] = 32'hDEAD; wd[1] = 32'hBEEF;
    do_write(32'h20, 1, 2'b01, 3'd2, 0, -1);
    do_write(32'h20, 0, 2'b01, 3'd1, 0, -1);
    do_write(32'h20, 0, 2'b11, 3'd2, 0, -1);
    do_write(32'd1024, 0, 2'b01, 3'd2, 0, -1);
    do_read(32'h20, 1, 2'b01, 3'd2, 0);
    do_read(32'd1024, 0, 2'b01, 3'd2, 0);
    do_read(32'h3FC, 1, 2'b01, 3'd2, 0);
  endtask

  task automatic test_collision();
    s_axi_araddr = 32'h10; s_axi_arlen = 8'd0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1; mon_ar = 1; ar_early = 0;
    wd[0] = 32'h5555_0001; ws[0] = 4'hF;
    do_write(32'h30, 0, 2'b01, 3'd2, 0, -1);
    mon_ar = 0;
    n_chk++;
    if (ar_early !== 1'b0) begin n_fail++; $display("FAIL collision_ar_early got %b want 0", ar_early); end
    do_read(32'h10, 0, 2'b01, 3'd2, 0);
  endtask

  task automatic test_rdwait_stall();
    do_read(32'h10, 3, 2'b01, 3'd2, 1);
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin wd[i] = 32'hE0 + 32'(i); ws[i] = 4'hF; end
    do_write(32'h50, 3, 2'b01, 3'd2, 3, -1);
    for (int i = 0; i < 4; i++) wd[i] = 32'h21 + 32'(i);
    do_write(32'h50, 3, 2'b01, 3'd2, 3, 2);
    reset = 0;
    #1;
    n_chk++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast,
         s_axi_bresp, s_axi_rresp, s_axi_rdata} !== '0) begin
      n_fail++; $display("FAIL reset_mid_outputs got wready=%b bvalid=%b want all outputs 0", s_axi_wready, s_axi_bvalid);
    end
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    wd[0] = 32'h9999_0000; ws[0] = 4'hF;
    do_write(32'h60, 0, 2'b01, 3'd2, 0, -1);
    do_read(32'h50, 3, 2'b01, 3'd2, 0);
    do_read(32'h60, 0, 2'b01, 3'd2, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mdl[i] = '0;
    test_reset();
    test_incr();
    test_strobe();
    test_wrap();
    test_slverr();
    test_collision();
    test_rdwait_stall();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule
